stream_mux_nway: RTL and testbench
==================================

# stream_mux_nway

Parametrised N-input, registered stream multiplexer with valid/ready handshaking, the next generation of the processor's 2:1 datapath mux. It selects one of NUM_IN channels of WIDTH bits each, either by a software-loaded select register or by round-robin arbitration. The output is a single register stage with full throughput and backpressure. It sits between operand/result sources and shared consumers, such as the writeback bus and the memory port.

## Interface

Parameters:
- WIDTH, 72, data width per channel in bits
- NUM_IN, 4, number of input channels (≥2)
- SELW, $clog2(NUM_IN), width of select/channel index (derived; do not override)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready (combinational)
- mode_rr  input  1  1 = round-robin arbitration, 0 = fixed select
- sel  input  SELW  fixed-mode channel index
- sel_load  input  1  load sel into sel_q
- out_data  output  WIDTH  registered output data
- out_ch  output  SELW  source channel index of out_data
- out_valid  output  1  output holds valid word
- out_ready  input  1  downstream accepts word

## Operation

- Capture enable: cap_en = !out_valid || out_ready.
- Grant: a one-hot grant vector g selects at most one channel per cycle. in_ready[k] = g[k] && cap_en. in_ready is forced to 0 while rst is high.
- Transfer on channel k when in_valid[k] && in_ready[k]. On that edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- If out_valid is set, out_ready is high and no transfer occurs, then out_valid <= 0. If out_ready is low, all output registers hold.
- Fixed mode (mode_rr=0):
  - g[k] = (k == sel_q).
  - If sel_q ≥ NUM_IN, no grant is issued and all in_ready are 0.
  - sel_load on an edge writes sel_q <= sel. The new value takes effect next cycle. A transfer in the same cycle uses the old sel_q.
- Round-robin mode (mode_rr=1):
  - Grant goes to the first channel with in_valid set, searching from rr_ptr upward and wrapping modulo NUM_IN.
  - After a transfer from channel k, rr_ptr <= (k+1) mod NUM_IN. rr_ptr holds when there is no transfer.
  - sel_q is still loadable but has no effect.
- Mode switch takes effect on the next grant evaluation. It does not disturb out_* or rr_ptr.
- Upstream valid is not required to be held when ready is low. Data on channels that are not granted is ignored.

## Timing

- Latency is 1 cycle from input transfer to out_valid.
- Throughput is one word per cycle when out_ready is held high.
- Simultaneous pop and push (out_valid=1, out_ready=1, new transfer) replaces the word with no bubble.
- Reset values: out_valid=0, out_data=0, out_ch=0, sel_q=0, rr_ptr=0.
- Reset asserted mid-stream discards the held word. in_ready is 0 during the reset cycle.
- All state updates occur on the rising edge of clk. No combinational path exists from in_valid to out_*. There is a combinational path from out_ready and in_valid to in_ready.

## Configuration

- STREAM_MUX_RR_EN:
  - Defined: round-robin logic and rr_ptr are compiled in, and mode_rr behaves as specified.
  - Undefined: round-robin logic and rr_ptr are removed, mode_rr is ignored, and the block is always in fixed mode. The mode_rr port remains on the interface.

## Test plan

- Reset, then fixed mode with sel=2 loaded.
  - Stimulus: in_valid=4'b1111, channel data k = 72'h0 + k*72'h111, out_ready=1.
  - Required: out_valid rises 1 cycle later, out_data=72'h222, out_ch=2, in_ready=4'b0100 every cycle.
- Backpressure in fixed mode.
  - Stimulus: hold out_ready=0 for 3 cycles with a word loaded.
  - Required: out_data is stable, in_ready=0. On release, the next word follows with no bubble and no loss or duplication (scoreboard compares).
- Round-robin with all four channels valid continuously.
  - Required: out_ch sequence 0,1,2,3,0,1… and one word per cycle.
  - Stimulus: drop channel 1 valid.
  - Required: sequence becomes 0,2,3,0.
- Round-robin wrap.
  - Stimulus: rr_ptr=3, only channel 0 valid.
  - Required: grant goes to 0 and rr_ptr becomes 1.
- sel_load=1 with sel=3 in the same cycle as a channel-0 transfer.
  - Required: that word has out_ch=0; the following word has out_ch=3.
- Reset asserted while out_valid=1 and out_ready=0.
  - Required: out_valid=0 and out_data=0 the next cycle, and in_ready=0 during reset.
- Build without STREAM_MUX_RR_EN.
  - Stimulus: mode_rr=1.
  - Required: behaviour matches fixed mode.

Source files
------------

// File: rtl/stream_mux_nway.sv
// stream_mux_nway: NUM_IN-way registered stream mux, fixed select or round-robin (round-robin under STREAM_MUX_RR_EN).
// Latency: 1 cycle from input handshake to out_valid; sustains one word per cycle.
// Backpressure: out_ready low with a word held freezes the output stage and drops every in_ready.
module stream_mux_nway #(
  parameter int WIDTH  = 72,
  parameter int NUM_IN = 4,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode_rr,
  input  logic [SELW-1:0]         sel,
  input  logic                    sel_load,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SELW-1:0]   selQ;
  logic              selInRange;
  logic              capEn;
  logic [NUM_IN-1:0] grantFix;
  logic [NUM_IN-1:0] grant;
  logic [SELW-1:0]   grantIdx;
  logic [WIDTH-1:0]  muxData;
  logic              xfer;

  assign capEn      = !out_valid || out_ready;
  assign selInRange = ({1'b0, selQ} < (SELW+1)'(NUM_IN));

  // An out-of-range select register grants nobody.
  always_comb begin
    grantFix = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (selInRange && (selQ == SELW'(k))) begin
        grantFix[k] = 1'b1;
      end
    end
  end

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0]   rrPtr;
  logic [SELW-1:0]   rrIdx;
  logic [SELW:0]     rrSum;
  logic              rrFound;
  logic [NUM_IN-1:0] grantRr;

  // First requesting channel at or after rrPtr, wrapping modulo NUM_IN.
  always_comb begin
    rrIdx   = '0;
    rrSum   = '0;
    rrFound = 1'b0;
    grantRr = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rrSum = {1'b0, rrPtr} + (SELW+1)'(i);
      if (rrSum >= (SELW+1)'(NUM_IN)) begin
        rrSum = rrSum - (SELW+1)'(NUM_IN);
      end
      if (!rrFound && in_valid[rrSum[SELW-1:0]]) begin
        rrFound = 1'b1;
        rrIdx   = rrSum[SELW-1:0];
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      grantRr[k] = rrFound && (rrIdx == SELW'(k));
    end
  end

  assign grant = mode_rr ? grantRr : grantFix;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr <= '0;
    end else if (xfer && mode_rr) begin
      rrPtr <= (grantIdx == SELW'(NUM_IN-1)) ? '0 : grantIdx + 1'b1;
    end
  end
`else
  logic unusedModeRr;

  assign unusedModeRr = mode_rr;
  assign grant        = grantFix;
`endif

  // Grant is one-hot or zero, so OR-reduction gives both the index and the data.
  always_comb begin
    grantIdx = '0;
    muxData  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant[k]) begin
        grantIdx = grantIdx | SELW'(k);
        muxData  = muxData | in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = rst ? '0 : (grant & {NUM_IN{capEn}});
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      selQ      <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= muxData;
        out_ch    <= grantIdx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (sel_load) begin
        selQ <= sel;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nway.sv
// Bench for stream_mux_nway: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_stream_mux_nway;

  localparam int WIDTH  = 72;
  localparam int NUM_IN = 4;
  localparam int SELW   = 2;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] inData;
  logic [NUM_IN-1:0]       inValid;
  logic [NUM_IN-1:0]       inReady;
  logic                    modeRr;
  logic [SELW-1:0]         sel;
  logic                    selLoad;
  logic [WIDTH-1:0]        outData;
  logic [SELW-1:0]         outCh;
  logic                    outValid;
  logic                    outReady;

  always #5 clk = ~clk;

  stream_mux_nway #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (inData),
    .in_valid (inValid),
    .in_ready (inReady),
    .mode_rr  (modeRr),
    .sel      (sel),
    .sel_load (selLoad),
    .out_data (outData),
    .out_ch   (outCh),
    .out_valid(outValid),
    .out_ready(outReady)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: the word the output stage should hold, plus select/pointer.
  bit               mValid;
  logic [WIDTH-1:0] mData;
  int               mCh;
  int               mSelQ;
  int               mPtr;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int refGrant();
    if (RR_EN && modeRr) begin
      for (int i = 0; i < NUM_IN; i++) begin
        int c;
        c = (mPtr + i) % NUM_IN;
        if (inValid[c]) return c;
      end
      return -1;
    end
    if (mSelQ < NUM_IN) return mSelQ;
    return -1;
  endfunction

  // Inputs are set by the caller just after a rising edge; one clock is consumed.
  task automatic step();
    int               g;
    bit               capEn;
    bit               xfer;
    logic [NUM_IN-1:0] expRdy;
    @(negedge clk);
    g      = refGrant();
    capEn  = !mValid || outReady;
    expRdy = '0;
    xfer   = 1'b0;
    if (!rst && g >= 0 && capEn) begin
      expRdy[g] = 1'b1;
      xfer      = inValid[g];
    end
    checkEq("in_ready", inReady, expRdy);
    if (rst) begin
      mValid = 1'b0;
      mData  = '0;
      mCh    = 0;
      mSelQ  = 0;
      mPtr   = 0;
    end else begin
      if (xfer) begin
        mValid = 1'b1;
        mData  = inData[g*WIDTH +: WIDTH];
        mCh    = g;
        if (RR_EN && modeRr) mPtr = (g + 1) % NUM_IN;
      end else if (outReady) begin
        mValid = 1'b0;
      end
      if (selLoad) mSelQ = int'(sel);
    end
    @(posedge clk);
    #1;
    checkEq("out_valid", outValid, mValid);
    checkEq("out_data", outData, mData);
    checkEq("out_ch", outCh, mCh);
  endtask

  task automatic setPattern();
    for (int k = 0; k < NUM_IN; k++) inData[k*WIDTH +: WIDTH] = 72'h111 * WIDTH'(k);
  endtask

  task automatic randData();
    for (int k = 0; k < NUM_IN; k++) inData[k*WIDTH +: WIDTH] = WIDTH'({$urandom, $urandom, $urandom});
  endtask

  initial begin
    int rrExp[4];
    rst = 1'b1; inData = '0; inValid = '0; modeRr = 1'b0;
    sel = '0; selLoad = 1'b0; outReady = 1'b1;
    mValid = 1'b0; mData = '0; mCh = 0; mSelQ = 0; mPtr = 0;
    step();
    step();

    // Fixed select of channel 2.
    rst = 1'b0; sel = 2'd2; selLoad = 1'b1;
    step();
    selLoad = 1'b0; setPattern(); inValid = 4'b1111;
    step();
    checkEq("fix_data", outData, 72'h222);
    checkEq("fix_ch", outCh, 2);
    step();
    step();

    // Backpressure then release with fresh words.
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin randData(); step(); end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin randData(); step(); end

`ifdef STREAM_MUX_RR_EN
    modeRr = 1'b1; inValid = 4'b1111;
    for (int i = 0; i < 5; i++) begin randData(); step(); checkEq("rr_seq", outCh, i % 4); end
    inValid = 4'b1101;
    rrExp = '{2, 3, 0, 2};
    for (int i = 0; i < 4; i++) begin randData(); step(); checkEq("rr_drop1", outCh, rrExp[i]); end
    inValid = 4'b0001;
    step();
    checkEq("rr_wrap", outCh, 0);
    inValid = 4'b1111;
    step();
    checkEq("rr_after_wrap", outCh, 1);
`endif

    // Select load coinciding with a channel-0 transfer.
    modeRr = 1'b0; sel = 2'd0; selLoad = 1'b1; inValid = 4'b0000;
    step();
    sel = 2'd3; inValid = 4'b1111; setPattern();
    step();
    checkEq("sel_old", outCh, 0);
    selLoad = 1'b0;
    step();
    checkEq("sel_new", outCh, 3);

    // Reset while a word is held under backpressure.
    outReady = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkEq("rst_vld", outValid, 0);
    checkEq("rst_dat", outData, 0);
    rst = 1'b0; outReady = 1'b1;

    // mode_rr raised with select 1 loaded.
    sel = 2'd1; selLoad = 1'b1;
    step();
    selLoad = 1'b0; modeRr = 1'b1;
    step();
    step();
`ifndef STREAM_MUX_RR_EN
    checkEq("norr_ch", outCh, 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(63) == 0);
      if ($urandom_range(31) == 0) modeRr = ~modeRr;
      sel      = SELW'($urandom);
      selLoad  = ($urandom_range(7) == 0);
      inValid  = NUM_IN'($urandom);
      outReady = ($urandom_range(3) != 0);
      randData();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
